// File: rtl/aes_output_buffer.sv
// Captures a finished AES block on the rising edge of done_i and streams it out
// LSB word first over valid/ready; overlapping results are dropped and flagged.
module aes_output_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WORDS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done_i,
    input  logic [DATA_W*WORDS-1:0]  text_i,
    output logic [DATA_W-1:0]        text_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     last_o,
    output logic                     busy_o,
    output logic                     ovf_o,
    input  logic                     clr_ovf_i
);

    localparam int unsigned BLK_W = DATA_W * WORDS;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;

    logic               cap;
    logic               hs;
    logic               final_hs;

    assign cap      = done_i & ~done_q;
    assign hs       = (state_q == SEND) & ready_i;
    assign final_hs = hs & (cnt_q == CNT_LAST);

    // Next-state: capture, shift on handshake, reload seamlessly on the final word
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (cap) begin
                    shreg_d = text_i;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (final_hs) begin
                    cnt_d = '0;
                    if (cap) begin
                        shreg_d = text_i;
                    end else begin
                        shreg_d = shreg_q >> DATA_W;
                        state_d = IDLE;
                    end
                end else if (hs) begin
                    shreg_d = shreg_q >> DATA_W;
                    cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase

        // A set from a dropped block overrides a simultaneous clear
        if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end
        if ((state_q == SEND) && cap && !final_hs) begin
            ovf_d = 1'b1;
        end

        valid_d = (state_d == SEND);
        busy_d  = (state_d == SEND);
        last_d  = (state_d == SEND) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_i;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign text_o  = shreg_q[DATA_W-1:0];
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_aes_output_buffer.sv
// Directed, table-driven bench for aes_output_buffer: each row is one clock of
// inputs plus the outputs expected just after that edge.
module tb_aes_output_buffer;

    localparam logic [127:0] T = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] A = {4{32'haaaaaaaa}};
    localparam logic [127:0] B = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

    logic         clk;
    logic         rst;
    logic         done_i;
    logic [127:0] text_i;
    logic [31:0]  text_o;
    logic         valid_o;
    logic         ready_i;
    logic         last_o;
    logic         busy_o;
    logic         ovf_o;
    logic         clr_ovf_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         done;
        logic [127:0] text;
        logic         ready;
        logic         clr;
        logic [31:0]  e_text;
        logic         e_valid;
        logic         e_last;
        logic         e_busy;
        logic         e_ovf;
    } vec_t;

    vec_t vecs[$];

    aes_output_buffer #(.DATA_W(32), .WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_i    (done_i),
        .text_i    (text_i),
        .text_o    (text_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .ovf_o     (ovf_o),
        .clr_ovf_i (clr_ovf_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    function automatic vec_t mk(input logic d, input logic [127:0] t, input logic r,
                                input logic c, input logic [31:0] et, input logic ev,
                                input logic el, input logic eb, input logic eo);
        vec_t v;
        v.done = d; v.text = t; v.ready = r; v.clr = c;
        v.e_text = et; v.e_valid = ev; v.e_last = el; v.e_busy = eb; v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] et, input logic ev,
                           input logic el, input logic eb, input logic eo);
        chk({tag, ".text"},  text_o,          et);
        chk({tag, ".valid"}, 32'(valid_o),    32'(ev));
        chk({tag, ".last"},  32'(last_o),     32'(el));
        chk({tag, ".busy"},  32'(busy_o),     32'(eb));
        chk({tag, ".ovf"},   32'(ovf_o),      32'(eo));
    endtask

    task automatic step(input logic d, input logic [127:0] t, input logic r, input logic c);
        @(negedge clk);
        done_i = d; text_i = t; ready_i = r; clr_ovf_i = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Basic stream, ready always high; done_i held high across the block
        vecs.push_back(mk(1, T, 1, 0, 32'hccddeeff, 1, 0, 1, 0));
        vecs.push_back(mk(1, T, 1, 0, 32'h8899aabb, 1, 0, 1, 0));
        vecs.push_back(mk(1, T, 1, 0, 32'h44556677, 1, 0, 1, 0));
        vecs.push_back(mk(1, T, 1, 0, 32'h00112233, 1, 1, 1, 0));
        vecs.push_back(mk(0, T, 1, 0, 32'h00000000, 0, 0, 0, 0));
        // Stalls with ready 1,0,0,1,0,1,1; done_i held high must not recapture
        vecs.push_back(mk(1, T, 1, 0, 32'hccddeeff, 1, 0, 1, 0));
        vecs.push_back(mk(1, T, 1, 0, 32'h8899aabb, 1, 0, 1, 0));
        vecs.push_back(mk(1, T, 0, 0, 32'h8899aabb, 1, 0, 1, 0));
        vecs.push_back(mk(1, T, 0, 0, 32'h8899aabb, 1, 0, 1, 0));
        vecs.push_back(mk(1, T, 1, 0, 32'h44556677, 1, 0, 1, 0));
        vecs.push_back(mk(1, T, 0, 0, 32'h44556677, 1, 0, 1, 0));
        vecs.push_back(mk(1, T, 1, 0, 32'h00112233, 1, 1, 1, 0));
        vecs.push_back(mk(1, T, 1, 0, 32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(1, T, 1, 0, 32'h00000000, 0, 0, 0, 0));
        // Back-to-back: new edge on the final handshake reloads with no bubble
        vecs.push_back(mk(0, T, 1, 0, 32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(1, T, 1, 0, 32'hccddeeff, 1, 0, 1, 0));
        vecs.push_back(mk(0, T, 1, 0, 32'h8899aabb, 1, 0, 1, 0));
        vecs.push_back(mk(0, T, 1, 0, 32'h44556677, 1, 0, 1, 0));
        vecs.push_back(mk(0, T, 1, 0, 32'h00112233, 1, 1, 1, 0));
        vecs.push_back(mk(1, A, 1, 0, 32'haaaaaaaa, 1, 0, 1, 0));
        vecs.push_back(mk(1, A, 1, 0, 32'haaaaaaaa, 1, 0, 1, 0));
        vecs.push_back(mk(1, A, 1, 0, 32'haaaaaaaa, 1, 0, 1, 0));
        vecs.push_back(mk(1, A, 1, 0, 32'haaaaaaaa, 1, 1, 1, 0));
        vecs.push_back(mk(0, A, 1, 0, 32'h00000000, 0, 0, 0, 0));
        // Drop mid-block sets ovf; block 1 completes intact; clear; clear+drop
        vecs.push_back(mk(1, T, 1, 0, 32'hccddeeff, 1, 0, 1, 0));
        vecs.push_back(mk(0, T, 1, 0, 32'h8899aabb, 1, 0, 1, 0));
        vecs.push_back(mk(1, A, 0, 0, 32'h8899aabb, 1, 0, 1, 1));
        vecs.push_back(mk(0, A, 1, 0, 32'h44556677, 1, 0, 1, 1));
        vecs.push_back(mk(0, A, 1, 0, 32'h00112233, 1, 1, 1, 1));
        vecs.push_back(mk(0, A, 1, 0, 32'h00000000, 0, 0, 0, 1));
        vecs.push_back(mk(0, A, 0, 1, 32'h00000000, 0, 0, 0, 0));
        vecs.push_back(mk(1, T, 0, 0, 32'hccddeeff, 1, 0, 1, 0));
        vecs.push_back(mk(0, T, 0, 0, 32'hccddeeff, 1, 0, 1, 0));
        vecs.push_back(mk(1, A, 0, 1, 32'hccddeeff, 1, 0, 1, 1));
        vecs.push_back(mk(0, A, 1, 0, 32'h8899aabb, 1, 0, 1, 1));
        vecs.push_back(mk(0, A, 1, 0, 32'h44556677, 1, 0, 1, 1));
        vecs.push_back(mk(0, A, 1, 0, 32'h00112233, 1, 1, 1, 1));
        vecs.push_back(mk(0, A, 1, 0, 32'h00000000, 0, 0, 0, 1));
        vecs.push_back(mk(0, A, 0, 1, 32'h00000000, 0, 0, 0, 0));

        // Reset asserted at time zero with ready high; outputs zero without a clock edge
        rst = 1'b1; done_i = 1'b0; text_i = '0; ready_i = 1'b1; clr_ovf_i = 1'b0;
        #1;
        chk_all("rst_async", 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all("rst_release", 32'h0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].done, vecs[i].text, vecs[i].ready, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].e_text, vecs[i].e_valid,
                    vecs[i].e_last, vecs[i].e_busy, vecs[i].e_ovf);
        end

        // Async reset between edges after two words; next block restarts at word 0
        step(1, T, 1, 0);
        chk_all("mid_w0", 32'hccddeeff, 1, 0, 1, 0);
        step(0, T, 1, 0);
        chk_all("mid_w1", 32'h8899aabb, 1, 0, 1, 0);
        step(0, T, 1, 0);
        chk_all("mid_w2", 32'h44556677, 1, 0, 1, 0);
        #1 rst = 1'b1;
        #1;
        chk_all("mid_rst", 32'h0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        step(1, B, 1, 0);
        chk_all("post_w0", 32'h03020100, 1, 0, 1, 0);
        step(0, B, 1, 0);
        chk_all("post_w1", 32'h07060504, 1, 0, 1, 0);
        step(0, B, 1, 0);
        chk_all("post_w2", 32'h0b0a0908, 1, 0, 1, 0);
        step(0, B, 1, 0);
        chk_all("post_w3", 32'h0f0e0d0c, 1, 1, 1, 0);
        step(0, B, 1, 0);
        chk_all("post_idle", 32'h0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
